sram_1rw_37x1024_ctrl: RTL and testbench

Synchronous controller that drives the 37x1024 single-port (1RW) SRAM macro from a valid/ready request interface. It registers every macro command, captures read data when the macro presents it, and buffers responses in a 3-entry FIFO with credit-based backpressure. An optional post-reset sweep writes zeros to every word. It sits between the core-side memory adapter and the SRAM macro instance.

---
 rtl/sram_1rw_37x1024_ctrl.sv | 147 ++++++++++++++
 tb/tb_sram_1rw_37x1024_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw_37x1024_ctrl.sv
// Valid/ready front end for a 1RW SRAM macro: registered command stage, two-cycle
// read pipeline into a 3-entry response FIFO with read credits, optional zero sweep after reset.
module sram_1rw_37x1024_ctrl #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 37,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_data,
  input  logic              i_req_spare_wen,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_data,
  output logic              o_busy,
  output logic              o_csb0,
  output logic              o_web0,
  output logic              o_spare_wen0,
  output logic [ADDR_W-1:0] o_addr0,
  output logic [DATA_W-1:0] o_din0,
  input  logic [DATA_W-1:0] i_dout0
);

  localparam int FIFO_D = 3;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] ST_INIT  = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_csb;
  logic              r_web;
  logic              r_spare_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic              r_rd_a;
  logic              r_rd_b;
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [1:0]        r_count;

  logic              w_push;
  logic              w_pop;
  logic [2:0]        w_inflight;
  logic              w_credit;
  logic              w_accept;
  logic [DATA_W-1:0] w_entry [FIFO_D];

  // Every read already in the pipe owns a FIFO slot, so overflow cannot happen.
  assign w_push     = r_rd_b;
  assign w_pop      = (r_count != 2'd0) && i_resp_ready;
  assign w_inflight = {1'b0, r_count} + {2'b00, r_rd_a} + {2'b00, r_rd_b} - {2'b00, w_pop};
  assign w_credit   = w_inflight < 3'd3;
  assign o_req_ready = !i_reset && (r_state == ST_RUN) && (i_req_write || w_credit);
  assign w_accept   = i_req_valid && o_req_ready;

  assign o_busy       = (r_state == ST_CLEAR);
  assign o_csb0       = r_csb;
  assign o_web0       = r_web;
  assign o_spare_wen0 = r_spare_wen;
  assign o_addr0      = r_addr;
  assign o_din0       = r_din;
  assign o_resp_valid = (r_count != 2'd0);
  assign o_resp_data  = (r_rd_ptr == 2'd2) ? w_entry[2] :
                        (r_rd_ptr == 2'd1) ? w_entry[1] : w_entry[0];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_INIT;
      r_clr_cnt   <= '0;
      r_csb       <= 1'b1;
      r_web       <= 1'b1;
      r_spare_wen <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
      r_rd_a      <= 1'b0;
      r_rd_b      <= 1'b0;
    end else begin
      r_rd_b <= r_rd_a;
      if (r_state == ST_CLEAR) begin
        r_csb       <= 1'b0;
        r_web       <= 1'b0;
        r_spare_wen <= 1'b1;
        r_addr      <= r_clr_cnt;
        r_din       <= '0;
        r_rd_a      <= 1'b0;
        r_clr_cnt   <= r_clr_cnt + ADDR_W'(1);
        if (r_clr_cnt == CLR_LAST) begin
          r_state <= ST_RUN;
        end
      end else if (w_accept) begin
        r_csb       <= 1'b0;
        r_web       <= !i_req_write;
        r_spare_wen <= i_req_write && i_req_spare_wen;
        r_addr      <= i_req_addr;
        r_din       <= i_req_data;
        r_rd_a      <= !i_req_write;
      end else begin
        r_csb       <= 1'b1;
        r_web       <= 1'b1;
        r_spare_wen <= 1'b0;
        r_rd_a      <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == 2'd2) ? 2'd0 : r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == 2'd2) ? 2'd0 : r_rd_ptr + 2'd1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_D; gi++) begin : g_fifo
      logic [DATA_W-1:0] r_entry;
      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          r_entry <= '0;
        end else if (w_push && (r_wr_ptr == 2'(gi))) begin
          r_entry <= i_dout0;
        end
      end
      assign w_entry[gi] = r_entry;
    end
  endgenerate

endmodule

// File: tb/tb_sram_1rw_37x1024_ctrl.sv
// Self-checking bench: behavioural SRAM macro, array/queue reference model, one task per scenario.
module tb_sram_1rw_37x1024_ctrl;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 37;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_data = '0;
  logic              req_spare_wen = 1'b0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [DATA_W-1:0] resp_data;
  logic              busy;
  logic              csb0, web0, spare_wen0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] din0;
  logic [DATA_W-1:0] dout0 = '0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  sram_1rw_37x1024_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_ON_RESET(1'b1)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_data(req_data), .i_req_spare_wen(req_spare_wen),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_data(resp_data),
    .o_busy(busy), .o_csb0(csb0), .o_web0(web0), .o_spare_wen0(spare_wen0),
    .o_addr0(addr0), .o_din0(din0), .i_dout0(dout0)
  );

  // Macro: samples on the edge after the command is registered, spare column gated.
  logic [DATA_W-1:0] macro_mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) macro_mem[i] = DATA_W'({$urandom(), $urandom()});
  end
  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        macro_mem[addr0][DATA_W-2:0] <= din0[DATA_W-2:0];
        if (spare_wen0) macro_mem[addr0][DATA_W-1] <= din0[DATA_W-1];
      end else begin
        dout0 <= macro_mem[addr0];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: memory contents after every accepted request, responses in acceptance order.
  logic [DATA_W-1:0] ref_mem [1024];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  int                pop_cyc[$];

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      got_q.delete();
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    end else begin
      if (resp_valid && resp_ready) begin
        got_q.push_back(resp_data);
        pop_cyc.push_back(cyc);
      end
      if (req_valid && req_ready) begin
        if (req_write) begin
          if (req_spare_wen) ref_mem[req_addr] = req_data;
          else ref_mem[req_addr] = {ref_mem[req_addr][DATA_W-1], req_data[DATA_W-2:0]};
        end else begin
          exp_q.push_back(ref_mem[req_addr]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted; returns 1 time unit after the accept edge.
  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic sp);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      req_valid = 1'b1; req_write = wr; req_addr = a; req_data = d; req_spare_wen = sp;
      #1;
      acc = req_ready;
      tick();
    end
    req_valid = 1'b0;
    if (!acc) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout: addr=%h write=%0b never accepted, required acceptance", a, wr);
    end
  endtask

  task automatic test_reset();
    resp_ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({csb0, web0, spare_wen0} !== 3'b110) begin
      n_errors++; $display("FAIL reset_ctrl: csb/web/spare=%b, required 110", {csb0, web0, spare_wen0});
    end
    n_checks++;
    if (addr0 !== '0 || din0 !== '0) begin
      n_errors++; $display("FAIL reset_addr_din: addr0=%h din0=%h, required 0 0", addr0, din0);
    end
    n_checks++;
    if (resp_valid !== 1'b0 || resp_data !== '0) begin
      n_errors++; $display("FAIL reset_resp: valid=%b data=%h, required 0 0", resp_valid, resp_data);
    end
    n_checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      n_errors++; $display("FAIL reset_ready_busy: ready=%b busy=%b, required 0 1", req_ready, busy);
    end
  endtask

  task automatic test_sweep();
    rst = 1'b0;
    for (int k = 1; k <= 1024; k++) begin
      tick();
      n_checks++;
      if (csb0 !== 1'b0 || web0 !== 1'b0 || spare_wen0 !== 1'b1 || din0 !== '0 ||
          addr0 !== ADDR_W'(k - 1) || busy !== (k < 1024) || req_ready !== (k == 1024) ||
          resp_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL sweep_cycle%0d: csb=%b web=%b spare=%b din=%h addr=%h busy=%b ready=%b, required 0 0 1 0 %h %b %b",
                 k, csb0, web0, spare_wen0, din0, addr0, busy, req_ready, ADDR_W'(k - 1), k < 1024, k == 1024);
      end
    end
    issue(1'b0, 10'h3FF, '0, 1'b0);
    repeat (2) tick();
    n_checks++;
    if (resp_valid !== 1'b1 || resp_data !== '0) begin
      n_errors++; $display("FAIL sweep_read_3ff: valid=%b data=%h, required 1 0", resp_valid, resp_data);
    end
    repeat (2) tick();
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_write_read();
    resp_ready = 1'b1;
    issue(1'b1, 10'h155, 37'h1_2345_6789, 1'b1);
    n_checks++;
    if (csb0 !== 1'b0 || web0 !== 1'b0 || spare_wen0 !== 1'b1 || addr0 !== 10'h155 || din0 !== 37'h1_2345_6789) begin
      n_errors++; $display("FAIL write_cmd: csb=%b web=%b spare=%b addr=%h din=%h, required 0 0 1 155 123456789",
                           csb0, web0, spare_wen0, addr0, din0);
    end
    issue(1'b0, 10'h155, '0, 1'b1);
    n_checks++;
    if (csb0 !== 1'b0 || web0 !== 1'b1 || spare_wen0 !== 1'b0 || addr0 !== 10'h155) begin
      n_errors++; $display("FAIL read_cmd: csb=%b web=%b spare=%b addr=%h, required 0 1 0 155",
                           csb0, web0, spare_wen0, addr0);
    end
    tick();
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_errors++; $display("FAIL read_latency_early: resp_valid=%b one edge after accept, required 0", resp_valid);
    end
    tick();
    n_checks++;
    if (resp_valid !== 1'b1 || resp_data !== 37'h1_2345_6789) begin
      n_errors++; $display("FAIL write_read: valid=%b data=%h, required 1 123456789", resp_valid, resp_data);
    end
    repeat (2) tick();
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_spare_mask();
    logic seen;
    resp_ready = 1'b1;
    issue(1'b1, 10'h010, {DATA_W{1'b1}}, 1'b1);
    issue(1'b1, 10'h010, '0, 1'b0);
    issue(1'b0, 10'h010, '0, 1'b0);
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      if (resp_valid) seen = 1'b1;
      else tick();
    end
    n_checks++;
    if (!seen || resp_data !== 37'h10_0000_0000) begin
      n_errors++; $display("FAIL spare_mask: valid=%b data=%h, required 1 1000000000", seen, resp_data);
    end
    repeat (2) tick();
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random_writes();
    for (int i = 0; i < 64; i++) begin
      issue(1'b1, ADDR_W'(i), DATA_W'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)));
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] a [5];
    int idx;
    logic acc;
    for (int i = 0; i < 5; i++) a[i] = ADDR_W'($urandom_range(0, 63));
    exp_q.delete(); got_q.delete();
    resp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = a[idx];
      #1; acc = req_ready;
      tick();
      if (acc) idx++;
    end
    req_addr = a[idx];
    #1;
    n_checks++;
    if (idx != 3 || req_ready !== 1'b0) begin
      n_errors++; $display("FAIL bp_accept_count: accepted=%0d ready=%b, required 3 0", idx, req_ready);
    end
    req_write = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++; $display("FAIL bp_write_ready: ready=%b with full credit, required 1", req_ready);
    end
    req_write = 1'b0;
    req_valid = 1'b0;
    tick();
    resp_ready = 1'b1;
    for (int i = idx; i < 5; i++) issue(1'b0, a[i], '0, 1'b0);
    repeat (8) tick();
    n_checks++;
    if (got_q.size() != 5 || exp_q.size() != 5) begin
      n_errors++; $display("FAIL bp_resp_count: got=%0d model=%0d, required 5", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [DATA_W-1:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_errors++; $display("FAIL bp_resp_data: got=%h, required %h", g, e);
      end
    end
  endtask

  task automatic test_streaming();
    int drops;
    exp_q.delete(); got_q.delete(); pop_cyc.delete();
    resp_ready = 1'b1;
    drops = 0;
    for (int i = 0; i < 100; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = ADDR_W'($urandom_range(0, 63));
      #1;
      if (req_ready !== 1'b1) drops++;
      tick();
    end
    req_valid = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (drops != 0) begin
      n_errors++; $display("FAIL stream_ready: req_ready low in %0d cycles, required 0", drops);
    end
    n_checks++;
    if (pop_cyc.size() != 100 || pop_cyc[pop_cyc.size()-1] - pop_cyc[0] != 99) begin
      n_errors++; $display("FAIL stream_consecutive: responses=%0d span=%0d, required 100 99",
                           pop_cyc.size(), pop_cyc.size() > 0 ? pop_cyc[pop_cyc.size()-1] - pop_cyc[0] : -1);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [DATA_W-1:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_errors++; $display("FAIL stream_data: got=%h, required %h", g, e);
      end
    end
  endtask

  task automatic test_random_mix();
    logic acc;
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 300; i++) begin
      req_valid = 1'($urandom_range(0, 3) != 0);
      req_write = 1'($urandom_range(0, 2) == 0);
      req_addr = ADDR_W'($urandom_range(0, 15));
      req_data = DATA_W'({$urandom(), $urandom()});
      req_spare_wen = 1'($urandom_range(0, 1));
      resp_ready = 1'($urandom_range(0, 2) != 0);
      #1; acc = req_ready;
      tick();
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    repeat (8) tick();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL mix_resp_count: got=%0d, required %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [DATA_W-1:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_errors++; $display("FAIL mix_resp_data: got=%h, required %h", g, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    int k;
    int stale;
    resp_ready = 1'b0;
    issue(1'b0, 10'h155, '0, 1'b0);
    issue(1'b0, 10'h010, '0, 1'b0);
    rst = 1'b1;
    #1;
    n_checks++;
    if (csb0 !== 1'b1 || resp_valid !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) begin
      n_errors++; $display("FAIL midreset_async: csb=%b valid=%b ready=%b busy=%b, required 1 0 0 1",
                           csb0, resp_valid, req_ready, busy);
    end
    repeat (2) tick();
    rst = 1'b0;
    resp_ready = 1'b1;
    tick();
    n_checks++;
    if (csb0 !== 1'b0 || web0 !== 1'b0 || addr0 !== '0 || busy !== 1'b1) begin
      n_errors++; $display("FAIL midreset_restart: csb=%b web=%b addr=%h busy=%b, required 0 0 0 1",
                           csb0, web0, addr0, busy);
    end
    k = 1; stale = 0;
    while (busy && k < 1100) begin
      if (resp_valid) stale++;
      tick();
      k++;
    end
    repeat (4) begin
      if (resp_valid) stale++;
      tick();
    end
    n_checks++;
    if (k != 1024 || stale != 0 || got_q.size() != 0) begin
      n_errors++; $display("FAIL midreset_sweep: sweep_cycles=%0d stale=%0d, required 1024 0", k, stale + got_q.size());
    end
    issue(1'b0, 10'h155, '0, 1'b0);
    repeat (2) tick();
    n_checks++;
    if (resp_valid !== 1'b1 || resp_data !== '0) begin
      n_errors++; $display("FAIL midreset_read: valid=%b data=%h, required 1 0", resp_valid, resp_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_write_read();
    test_spare_mask();
    test_random_writes();
    test_backpressure();
    test_streaming();
    test_random_mix();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
